// File: rtl/vcmp_pkg.sv
// Shared types for the vector-compare sequencer: compare opcodes and the
// sequencer state encoding.
package vcmp_pkg;

    // Compare opcodes. Order and values match the external comparison unit.
    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_NE = 2'b01,
        CMP_GT = 2'b10,
        CMP_LT = 2'b11
    } cmp_op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } seq_state_e;

endpackage : vcmp_pkg

// File: rtl/vcmp_mask_accum.sv
// Response pipe and mask accumulator. It delays the issue strobe and element
// index by one cycle to line up with read data, then writes the predicate
// returned by the comparison unit into the matching mask bit.
module vcmp_mask_accum #(
    parameter int VLEN = 8,
    parameter int IDXW = $clog2(VLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_clear,
    input  logic            i_issue_valid,
    input  logic [IDXW-1:0] i_issue_idx,
    input  logic            i_predicate,
    output logic [VLEN-1:0] o_mask
);

    logic            r_pipe_valid;
    logic [IDXW-1:0] r_pipe_idx;
    logic [VLEN-1:0] r_mask;

    // Delay the issue strobe/index to the read-data cycle and set mask bits.
    always_ff @(posedge clk) begin
        // NOTE: the mask is a handful of flops, not a RAM, so it is reset like any other state.
        if (reset) begin
            r_pipe_valid <= 1'b0;
            r_pipe_idx   <= '0;
            r_mask       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_pipe_valid <= i_issue_valid;
            r_pipe_idx   <= i_issue_idx;
            if (i_clear) begin
                r_mask <= '0;
            end else if (r_pipe_valid) begin
                r_mask[r_pipe_idx] <= i_predicate;
            end
        end
    end

    assign o_mask = r_mask;

endmodule : vcmp_mask_accum

// File: rtl/vcmp_sequencer.sv
// Vector compare sequencer. Accepts one compare command, streams element
// pairs from two register-file read ports into an external comparison unit,
// collects the predicates into a mask and offers it on a valid/ready port.
module vcmp_sequencer
    import vcmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int VLEN  = 8,
    parameter int NREG  = 32,
    parameter int IDXW  = $clog2(VLEN),
    parameter int VLW   = $clog2(VLEN + 1),
    parameter int REGW  = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [REGW-1:0]  cmd_vs1,
    input  logic [REGW-1:0]  cmd_vs2,
    input  logic [VLW-1:0]   cmd_vl,
    output logic             rf_ren,
    output logic [REGW-1:0]  rf_vreg1,
    output logic [REGW-1:0]  rf_vreg2,
    output logic [IDXW-1:0]  rf_elem,
    input  logic [WIDTH-1:0] rf_rdata1,
    input  logic [WIDTH-1:0] rf_rdata2,
    output logic [WIDTH-1:0] cmp_in1,
    output logic [WIDTH-1:0] cmp_in2,
    output logic [1:0]       cmp_control,
    input  logic             cmp_predicate,
    output logic             mask_valid,
    input  logic             mask_ready,
    output logic [VLEN-1:0]  mask_data,
    output logic             busy
);

    seq_state_e      r_state;
    cmp_op_e         r_op;
    logic [REGW-1:0] r_vs1;
    logic [REGW-1:0] r_vs2;
    logic [VLW-1:0]  r_vl;
    logic [IDXW-1:0] r_idx;
    logic            r_cmd_ready;
    logic            r_busy;
    logic            r_rf_ren;
    logic            r_mask_valid;

    logic            w_accept;
    logic [VLW-1:0]  w_vl_clamped;
    logic            w_last;

    assign w_accept     = cmd_valid & r_cmd_ready;
    // Oversized lengths are treated as a full register.
    assign w_vl_clamped = (cmd_vl > VLW'(VLEN)) ? VLW'(VLEN) : cmd_vl;
    // r_vl is never 0 in RUN, so the subtraction cannot wrap there.
    assign w_last       = (VLW'(r_idx) == (r_vl - VLW'(1)));

    // Sequencer FSM with registered handshake and read-port controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_op         <= CMP_EQ;
            r_vs1        <= '0;
            r_vs2        <= '0;
            r_vl         <= '0;
            r_idx        <= '0;
            r_cmd_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_rf_ren     <= 1'b0;
            r_mask_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op        <= cmp_op_e'(cmd_op);
                        r_vs1       <= cmd_vs1;
                        r_vs2       <= cmd_vs2;
                        r_vl        <= w_vl_clamped;
                        r_idx       <= '0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_vl_clamped != '0) begin
                            r_state  <= RUN;
                            r_rf_ren <= 1'b1;
                        end else begin
                            // Empty vector: nothing to read, the cleared mask is the result.
                            r_state      <= DONE;
                            r_mask_valid <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_last) begin
                        r_state  <= DRAIN;
                        r_rf_ren <= 1'b0;
                        r_idx    <= '0;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                DRAIN: begin
                    // Last predicate lands in the mask at this edge.
                    r_state      <= DONE;
                    r_mask_valid <= 1'b1;
                end
                DONE: begin
                    if (mask_ready) begin
                        r_state      <= IDLE;
                        r_mask_valid <= 1'b0;
                        r_cmd_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    vcmp_mask_accum #(
        .VLEN (VLEN),
        .IDXW (IDXW)
    ) u_mask_accum (
        .clk           (clk),
        .reset         (reset),
        .i_clear       (w_accept),
        .i_issue_valid (r_rf_ren),
        .i_issue_idx   (r_idx),
        .i_predicate   (cmp_predicate),
        .o_mask        (mask_data)
    );

    assign cmd_ready   = r_cmd_ready;
    assign busy        = r_busy;
    assign rf_ren      = r_rf_ren;
    assign rf_vreg1    = r_vs1;
    assign rf_vreg2    = r_vs2;
    // Index is parked at 0 outside RUN.
    assign rf_elem     = r_idx;
    assign cmp_in1     = rf_rdata1;
    assign cmp_in2     = rf_rdata2;
    assign cmp_control = r_op;
    assign mask_valid  = r_mask_valid;

endmodule : vcmp_sequencer

// File: tb/tb_vcmp_sequencer.sv
// Directed self-checking bench for vcmp_sequencer. Provides a register-file
// model with one-cycle read latency and a combinational comparison unit.
module tb_vcmp_sequencer;

    localparam int WIDTH = 32;
    localparam int VLEN  = 8;
    localparam int NREG  = 32;
    localparam int IDXW  = 3;
    localparam int VLW   = 4;
    localparam int REGW  = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [REGW-1:0]  cmd_vs1;
    logic [REGW-1:0]  cmd_vs2;
    logic [VLW-1:0]   cmd_vl;
    logic             rf_ren;
    logic [REGW-1:0]  rf_vreg1;
    logic [REGW-1:0]  rf_vreg2;
    logic [IDXW-1:0]  rf_elem;
    logic [WIDTH-1:0] rf_rdata1;
    logic [WIDTH-1:0] rf_rdata2;
    logic [WIDTH-1:0] cmp_in1;
    logic [WIDTH-1:0] cmp_in2;
    logic [1:0]       cmp_control;
    logic             cmp_predicate;
    logic             mask_valid;
    logic             mask_ready;
    logic [VLEN-1:0]  mask_data;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;
    int ren_count = 0;
    int elem_q[$];
    int lat;

    logic [WIDTH-1:0] rf_mem [NREG][VLEN];

    always #5 clk = ~clk;

    vcmp_sequencer #(
        .WIDTH (WIDTH),
        .VLEN  (VLEN),
        .NREG  (NREG)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_vs1       (cmd_vs1),
        .cmd_vs2       (cmd_vs2),
        .cmd_vl        (cmd_vl),
        .rf_ren        (rf_ren),
        .rf_vreg1      (rf_vreg1),
        .rf_vreg2      (rf_vreg2),
        .rf_elem       (rf_elem),
        .rf_rdata1     (rf_rdata1),
        .rf_rdata2     (rf_rdata2),
        .cmp_in1       (cmp_in1),
        .cmp_in2       (cmp_in2),
        .cmp_control   (cmp_control),
        .cmp_predicate (cmp_predicate),
        .mask_valid    (mask_valid),
        .mask_ready    (mask_ready),
        .mask_data     (mask_data),
        .busy          (busy)
    );

    // Register file: data valid one cycle after a read-enabled edge.
    always @(posedge clk) begin
        if (rf_ren) begin
            rf_rdata1 <= rf_mem[rf_vreg1][rf_elem];
            rf_rdata2 <= rf_mem[rf_vreg2][rf_elem];
        end
    end

    // External comparison unit (unsigned).
    always_comb begin
        case (cmp_control)
            2'b00:   cmp_predicate = (cmp_in1 == cmp_in2);
            2'b01:   cmp_predicate = (cmp_in1 != cmp_in2);
            2'b10:   cmp_predicate = (cmp_in1 >  cmp_in2);
            default: cmp_predicate = (cmp_in1 <  cmp_in2);
        endcase
    end

    // Record issued element indices away from the active edge.
    always @(negedge clk) begin
        if (rf_ren) begin
            ren_count++;
            elem_q.push_back(int'(rf_elem));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] op, input logic [REGW-1:0] a,
                         input logic [REGW-1:0] b, input logic [VLW-1:0] vl);
        cmd_op    = op;
        cmd_vs1   = a;
        cmd_vs2   = b;
        cmd_vl    = vl;
        cmd_valid = 1'b1;
    endtask

    // Called right after the accept edge; lat=1 means mask_valid already high.
    task automatic wait_mask(output int l);
        l = 1;
        while (!mask_valid && l < 50) begin
            tick();
            l++;
        end
    endtask

    initial begin
        // Register file contents.
        for (int r = 0; r < NREG; r++)
            for (int e = 0; e < VLEN; e++)
                rf_mem[r][e] = 32'hDEAD_0000 + 32'(r * 16 + e);
        rf_mem[1][0] = 5; rf_mem[1][1] = 7; rf_mem[1][2] = 9; rf_mem[1][3] = 1;
        rf_mem[2][0] = 5; rf_mem[2][1] = 0; rf_mem[2][2] = 9; rf_mem[2][3] = 2;
        for (int e = 4; e < VLEN; e++) begin
            rf_mem[1][e] = 32'(e);
            rf_mem[2][e] = 32'(e);
        end
        for (int e = 0; e < VLEN; e++) begin
            rf_mem[3][e] = 32'(e);
            rf_mem[4][e] = 4;
            rf_mem[5][e] = 32'(100 + e);
            rf_mem[6][e] = 32'(100 + e);
        end

        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_vs1    = '0;
        cmd_vs2    = '0;
        cmd_vl     = '0;
        mask_ready = 1'b1;
        tick();
        tick();
        check("rst_cmd_ready",  32'(cmd_ready),   32'd1);
        check("rst_rf_ren",     32'(rf_ren),      32'd0);
        check("rst_rf_elem",    32'(rf_elem),     32'd0);
        check("rst_rf_vreg1",   32'(rf_vreg1),    32'd0);
        check("rst_rf_vreg2",   32'(rf_vreg2),    32'd0);
        check("rst_cmp_ctrl",   32'(cmp_control), 32'd0);
        check("rst_mask_valid", 32'(mask_valid),  32'd0);
        check("rst_mask_data",  32'(mask_data),   32'd0);
        check("rst_busy",       32'(busy),        32'd0);
        reset = 1'b0;
        tick();

        // vl=4 eq: A=[5,7,9,1] B=[5,0,9,2] -> 0101, latency 6.
        elem_q.delete();
        ren_count = 0;
        offer(2'b00, 5'd1, 5'd2, 4'd4);
        tick();
        cmd_valid = 1'b0;
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_cmd_ready", 32'(cmd_ready), 32'd0);
        wait_mask(lat);
        check("t1_latency", 32'(lat), 32'd6);
        check("t1_mask", 32'(mask_data), 32'h05);
        check("t1_ren_count", 32'(ren_count), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t1_elem%0d", i),
                  (i < elem_q.size()) ? 32'(elem_q[i]) : 32'hFFFF_FFFF, 32'(i));
        tick();
        check("t1_post_valid", 32'(mask_valid), 32'd0);
        check("t1_post_ready", 32'(cmd_ready), 32'd1);

        // vl=8 lt: A=0..7 B=4 -> 0x0F, latency 10.
        offer(2'b11, 5'd3, 5'd4, 4'd8);
        tick();
        cmd_valid = 1'b0;
        check("t2_cmp_ctrl", 32'(cmp_control), 32'd3);
        wait_mask(lat);
        check("t2_latency", 32'(lat), 32'd10);
        check("t2_mask_lt", 32'(mask_data), 32'h0F);
        tick();

        // vl=8 gt same data -> 0xE0.
        offer(2'b10, 5'd3, 5'd4, 4'd8);
        tick();
        cmd_valid = 1'b0;
        wait_mask(lat);
        check("t3_mask_gt", 32'(mask_data), 32'hE0);
        tick();

        // vl=0 ne: no reads, latency 1, mask 0.
        ren_count = 0;
        offer(2'b01, 5'd1, 5'd2, 4'd0);
        tick();
        cmd_valid = 1'b0;
        wait_mask(lat);
        check("t4_latency", 32'(lat), 32'd1);
        check("t4_mask", 32'(mask_data), 32'h00);
        tick();
        check("t4_ren_count", 32'(ren_count), 32'd0);

        // vl>VLEN clamps to VLEN: ne on equal data -> 0, latency 10.
        offer(2'b01, 5'd5, 5'd6, 4'd15);
        tick();
        cmd_valid = 1'b0;
        wait_mask(lat);
        check("t5_clamp_latency", 32'(lat), 32'd10);
        check("t5_clamp_mask", 32'(mask_data), 32'h00);
        tick();

        // Back-pressure in DONE with a second command pending.
        mask_ready = 1'b0;
        offer(2'b00, 5'd5, 5'd6, 4'd2);
        tick();
        offer(2'b00, 5'd1, 5'd2, 4'd4);
        wait_mask(lat);
        check("t6_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t6_hold_valid%0d", i), 32'(mask_valid), 32'd1);
            check($sformatf("t6_hold_mask%0d", i), 32'(mask_data), 32'h03);
            check($sformatf("t6_hold_ready%0d", i), 32'(cmd_ready), 32'd0);
        end
        mask_ready = 1'b1;
        tick();
        check("t6_idle_busy", 32'(busy), 32'd0);
        check("t6_idle_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("t6_second_accept", 32'(busy), 32'd1);
        wait_mask(lat);
        check("t6_second_latency", 32'(lat), 32'd6);
        check("t6_second_mask", 32'(mask_data), 32'h05);
        tick();

        // Back-to-back with mask_ready high: stale bits must not survive.
        offer(2'b11, 5'd3, 5'd4, 4'd8);
        tick();
        offer(2'b10, 5'd3, 5'd4, 4'd8);
        wait_mask(lat);
        check("t7_first_mask", 32'(mask_data), 32'h0F);
        tick();
        check("t7_gap_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("t7_second_busy", 32'(busy), 32'd1);
        wait_mask(lat);
        check("t7_second_mask", 32'(mask_data), 32'hE0);
        tick();

        // Reset mid-operation at element 3.
        offer(2'b00, 5'd1, 5'd2, 4'd8);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        check("t8_elem3", 32'(rf_elem), 32'd3);
        reset = 1'b1;
        tick();
        check("t8_rst_ready", 32'(cmd_ready), 32'd1);
        check("t8_rst_ren", 32'(rf_ren), 32'd0);
        check("t8_rst_mask", 32'(mask_data), 32'h00);
        check("t8_rst_busy", 32'(busy), 32'd0);
        check("t8_rst_valid", 32'(mask_valid), 32'd0);
        reset = 1'b0;
        tick();
        offer(2'b00, 5'd5, 5'd6, 4'd2);
        tick();
        cmd_valid = 1'b0;
        wait_mask(lat);
        check("t8_new_latency", 32'(lat), 32'd4);
        check("t8_new_mask", 32'(mask_data), 32'h03);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_vcmp_sequencer
